leaf_stream_packetizer: RTL and testbench
=========================================

LEAF_STREAM_PACKETIZER -- requirements
Module: leaf_stream_packetizer

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49, BFT packet width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32, user stream data width.
REQ-003 SHALL have parameters NUM_LEAF_BITS, NUM_PORT_BITS and NUM_ADDR_BITS, defaults 5, 4 and 7, widths of the destination leaf, port and address fields.
REQ-004 SHALL have parameter FREESPACE_INIT, default 128, initial credit count equal to the receiver buffer depth.
REQ-005 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64, the only legal non-zero credit-return amount.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 ap_start  input  1  level; enables transmission once sampled high.
REQ-009 dest_leaf  input  NUM_LEAF_BITS  destination leaf; sampled on the start edge.
REQ-010 dest_port  input  NUM_PORT_BITS  destination input port; sampled on the start edge.
REQ-011 din_TDATA  input  PAYLOAD_BITS  user output stream data.
REQ-012 din_TVALID  input  1  user data valid.
REQ-013 din_TREADY  output  1  packetizer accepts the word.
REQ-014 dout_leaf_interface2bft  output  PACKET_BITS  packet; bit 48 is the valid flag.
REQ-015 dout_ready  input  1  BFT accepts the current packet.
REQ-016 credit_vld  input  1  credit return strobe from the remote leaf.
REQ-017 credit_amt  input  NUM_ADDR_BITS+1  credits returned, 0 or FREESPACE_UPDATE_SIZE.
REQ-018 credits  output  NUM_ADDR_BITS+1  current credit count, for debug.

Function
REQ-019 Packet layout SHALL be: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
REQ-020 The FSM SHALL have states IDLE, RUN and NOCRED; reset enters IDLE.
REQ-021 IDLE->RUN SHALL occur on the first cycle ap_start=1, latching dest_leaf/dest_port; ap_start deassertion thereafter SHALL be ignored.
REQ-022 din_TREADY SHALL be 1 only when state=RUN, credits>0, and (output valid=0 or dout_ready=1).
REQ-023 A handshake (din_TVALID & din_TREADY) SHALL load the output register next cycle with valid=1, latched leaf/port, addr=wr_addr, payload=din_TDATA; latency is 1 cycle.
REQ-024 The output packet SHALL be held stable while valid=1 and dout_ready=0.
REQ-025 When valid=1, dout_ready=1 and there is no new handshake, valid SHALL clear next cycle; the other fields are don't-care when valid=0.
REQ-026 wr_addr SHALL reset to 0, increment by 1 per handshake, and wrap from 2^NUM_ADDR_BITS-1 to 0.
REQ-027 credits SHALL reset to FREESPACE_INIT and change per cycle by -1 per handshake, plus credit_amt when credit_vld=1.
REQ-028 On a simultaneous handshake and credit return, credits SHALL equal credits-1+credit_amt in one cycle.
REQ-029 credits SHALL saturate at FREESPACE_INIT; a return that would exceed it SHALL set sticky output bit overflow_err; credits SHALL never underflow.
REQ-030 RUN->NOCRED SHALL occur when a handshake takes credits to 0 with no credit return in the same cycle.
REQ-031 NOCRED->RUN SHALL occur on any credit_vld with credit_amt>0.
REQ-032 overflow_err  output  1  SHALL be added to the interface, reset 0.

Reset
REQ-033 Reset SHALL force: state=IDLE, output packet all zero (valid=0), din_TREADY=0, wr_addr=0, credits=FREESPACE_INIT, overflow_err=0, latched leaf/port=0.
REQ-034 Reset asserted mid-stream SHALL drop the pending packet; the output SHALL be 0 in the cycle after reset is sampled.

Verification
REQ-035 Start with leaf=3, port=2; send 0xDEADBEEF with dout_ready=1 -> one cycle later, packet bit48=1, leaf=3, port=2, addr=0, payload=0xDEADBEEF.
REQ-036 Send 130 words with no credit return -> 128 accepted, din_TREADY=0 afterwards, state=NOCRED, credits=0, last addr=127; addr wraps to 0 on word 129 after one return of 64.
REQ-037 Hold dout_ready=0 for 5 cycles with valid=1 -> packet held constant and din_TREADY=0; it releases 1 cycle after dout_ready=1.
REQ-038 At credits=1, handshake together with credit_vld and amt=64 -> credits=64, state stays RUN.
REQ-039 At credits=128, credit return of 64 -> credits stays 128, overflow_err=1.
REQ-040 Assert reset during back-to-back streaming -> all outputs at reset values next cycle; no packet sent until ap_start re-samples high.

Source files
------------

// File: rtl/leaf_stream_packetizer.sv
// Leaf stream packetizer: wraps user stream words into BFT packets
// with destination leaf/port, rolling address and credit flow control.
module leaf_stream_packetizer #(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 5,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int FREESPACE_INIT        = 128,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ap_start,
   input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
   input  logic [NUM_PORT_BITS-1:0] dest_port,
   input  logic [PAYLOAD_BITS-1:0]  din_TDATA,
   input  logic                     din_TVALID,
   output logic                     din_TREADY,
   output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
   input  logic                     dout_ready,
   input  logic                     credit_vld,
   input  logic [NUM_ADDR_BITS:0]   credit_amt,
   output logic [NUM_ADDR_BITS:0]   credits,
   output logic                     overflow_err
);

   localparam int CW = NUM_ADDR_BITS + 1;
   localparam logic [CW:0] CRED_MAX = (CW+1)'(FREESPACE_INIT);

   typedef enum logic [1:0] {IDLE, RUN, NOCRED} state_t;

   state_t                     state_q, state_d;
   logic [NUM_LEAF_BITS-1:0]   leaf_q;
   logic [NUM_PORT_BITS-1:0]   port_q;
   logic [NUM_ADDR_BITS-1:0]   addr_q;
   logic [CW-1:0]              cred_q, cred_d;
   logic                       ovf_q, ovf_d;
   logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
   logic [CW:0]                sum;
   logic                       hs;
   logic                       ret;

   assign hs  = din_TVALID & din_TREADY;
   assign ret = credit_vld & (credit_amt != '0);

   assign dout_leaf_interface2bft = pkt_q;
   assign credits                 = cred_q;
   assign overflow_err            = ovf_q;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: leave RUN only when the last credit is consumed
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ap_start) state_d = RUN;
         RUN:     if (hs && cred_d == '0) state_d = NOCRED;
         NOCRED:  if (ret) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // FSM output: accept only with credit and a free output slot
   always_comb begin
      din_TREADY = (state_q == RUN) && (cred_q != '0) &&
                   (!pkt_q[PACKET_BITS-1] || dout_ready);
   end

   // Credit update with saturation and sticky overflow flag
   always_comb begin
      sum = {1'b0, cred_q} - (CW+1)'(hs)
            + (credit_vld ? {1'b0, credit_amt} : '0);
      ovf_d = ovf_q;
      if (sum > CRED_MAX) begin
         cred_d = CW'(FREESPACE_INIT);
         ovf_d  = 1'b1;
      end else begin
         cred_d = sum[CW-1:0];
      end
   end

   // Output packet: load on handshake, drop valid once consumed
   always_comb begin
      pkt_d = pkt_q;
      if (hs)
         pkt_d = {1'b1, leaf_q, port_q, addr_q, din_TDATA};
      else if (dout_ready)
         pkt_d[PACKET_BITS-1] = 1'b0;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_q  <= '0;
         leaf_q <= '0;
         port_q <= '0;
         addr_q <= '0;
         cred_q <= CW'(FREESPACE_INIT);
         ovf_q  <= 1'b0;
      end else begin
         pkt_q  <= pkt_d;
         cred_q <= cred_d;
         ovf_q  <= ovf_d;
         if (state_q == IDLE && ap_start) begin
            leaf_q <= dest_leaf;
            port_q <= dest_port;
         end
         if (hs) addr_q <= addr_q + NUM_ADDR_BITS'(1);
      end
   end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Scoreboard bench for leaf_stream_packetizer: directed streams,
// credit exhaustion/return, backpressure, overflow and mid-stream reset.
module tb_leaf_stream_packetizer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ap_start;
   logic [4:0]  dest_leaf;
   logic [3:0]  dest_port;
   logic [31:0] din_TDATA;
   logic        din_TVALID;
   logic        din_TREADY;
   logic [48:0] dout;
   logic        dout_ready;
   logic        credit_vld;
   logic [7:0]  credit_amt;
   logic [7:0]  credits;
   logic        overflow_err;

   logic [48:0] q[$];
   logic [48:0] exp_pkt;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [4:0]  m_leaf;
   logic [3:0]  m_port;
   logic [6:0]  m_addr;
   int          m_cred;

   always #5 clk = ~clk;

   leaf_stream_packetizer dut (
      .clk                     (clk),
      .reset                   (reset),
      .ap_start                (ap_start),
      .dest_leaf               (dest_leaf),
      .dest_port               (dest_port),
      .din_TDATA               (din_TDATA),
      .din_TVALID              (din_TVALID),
      .din_TREADY              (din_TREADY),
      .dout_leaf_interface2bft (dout),
      .dout_ready              (dout_ready),
      .credit_vld              (credit_vld),
      .credit_amt              (credit_amt),
      .credits                 (credits),
      .overflow_err            (overflow_err)
   );

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every transfer to the BFT is checked against the queue
   always @(negedge clk) begin
      if (dout[48] === 1'b1 && dout_ready === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pkt: got %0h expected none", dout);
         end else begin
            exp_pkt = q.pop_front();
            chk("pkt", {15'd0, dout}, {15'd0, exp_pkt});
         end
      end
   end

   task automatic send_word(input logic [31:0] d);
      int k;
      k = 0;
      din_TDATA  = d;
      din_TVALID = 1'b1;
      @(negedge clk);
      while (din_TREADY !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (din_TREADY !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL tready_timeout: got %b expected 1", din_TREADY);
      end else begin
         q.push_back({1'b1, m_leaf, m_port, m_addr, d});
         m_addr = m_addr + 7'd1;
         m_cred = m_cred - 1;
      end
      @(posedge clk);
      #1 din_TVALID = 1'b0;
   endtask

   task automatic start(input logic [4:0] l, input logic [3:0] p);
      ap_start  = 1'b1;
      dest_leaf = l;
      dest_port = p;
      m_leaf    = l;
      m_port    = p;
      @(posedge clk);
      #1;
      ap_start  = 1'b0;
      dest_leaf = 5'h1f;
      dest_port = 4'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q.delete();
      m_addr = '0;
      m_cred = 128;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      ap_start   = 1'b0;
      dest_leaf  = '0;
      dest_port  = '0;
      din_TDATA  = '0;
      din_TVALID = 1'b0;
      dout_ready = 1'b0;
      credit_vld = 1'b0;
      credit_amt = '0;
      m_leaf     = '0;
      m_port     = '0;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_pkt", {15'd0, dout}, 64'd0);
      chk("rst_tready", {63'd0, din_TREADY}, 64'd0);
      chk("rst_credits", {56'd0, credits}, 64'd128);
      chk("rst_ovf", {63'd0, overflow_err}, 64'd0);
      step();
      din_TVALID = 1'b1;
      @(negedge clk);
      chk("idle_tready", {63'd0, din_TREADY}, 64'd0);
      step();
      din_TVALID = 1'b0;

      // single word, 1-cycle latency
      dout_ready = 1'b1;
      start(5'd3, 4'd2);
      send_word(32'hDEADBEEF);
      @(negedge clk);
      chk("first_pkt", {15'd0, dout}, 64'h1_1900_DEAD_BEEF);
      chk("cred_127", {56'd0, credits}, 64'd127);
      step();
      @(negedge clk);
      chk("valid_clear", {63'd0, dout[48]}, 64'd0);
      step();

      // credit exhaustion and return
      do_reset();
      start(5'd5, 4'd9);
      for (int i = 0; i < 128; i++) send_word(32'h1000_0000 + i);
      din_TVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nocred_tready", {63'd0, din_TREADY}, 64'd0);
         chk("cred_zero", {56'd0, credits}, 64'd0);
         step();
      end
      din_TVALID = 1'b0;
      credit_vld = 1'b1;
      credit_amt = 8'd64;
      step();
      credit_vld = 1'b0;
      m_cred     = m_cred + 64;
      @(negedge clk);
      chk("cred_64", {56'd0, credits}, 64'd64);
      chk("nocred_exit", {63'd0, din_TREADY}, 64'd1);
      step();
      send_word(32'h0000_0129);
      @(negedge clk);
      chk("wrap_addr", {57'd0, dout[38:32]}, 64'd0);
      step();

      // backpressure hold
      dout_ready = 1'b0;
      send_word(32'hA5A5_0001);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_pkt", {15'd0, dout},
             {15'd0, 1'b1, 5'd5, 4'd9, 7'd1, 32'hA5A5_0001});
         chk("stall_tready", {63'd0, din_TREADY}, 64'd0);
         step();
      end
      dout_ready = 1'b1;
      step();
      @(negedge clk);
      chk("stall_release", {63'd0, dout[48]}, 64'd0);
      step();

      // handshake and credit return on the same cycle at credits=1
      for (int i = 0; i < 61; i++) send_word(32'h2000_0000 + i);
      @(negedge clk);
      chk("cred_one", {56'd0, credits}, 64'd1);
      step();
      credit_vld = 1'b1;
      credit_amt = 8'd64;
      send_word(32'hC0DE_0000);
      credit_vld = 1'b0;
      m_cred     = m_cred + 64;
      @(negedge clk);
      chk("simul_cred", {56'd0, credits}, 64'd64);
      chk("simul_run", {63'd0, din_TREADY}, 64'd1);
      step();

      // saturation and sticky overflow
      credit_vld = 1'b1;
      step();
      credit_vld = 1'b0;
      @(negedge clk);
      chk("cred_full", {56'd0, credits}, 64'd128);
      chk("ovf_clear", {63'd0, overflow_err}, 64'd0);
      step();
      credit_vld = 1'b1;
      step();
      credit_vld = 1'b0;
      @(negedge clk);
      chk("cred_sat", {56'd0, credits}, 64'd128);
      chk("ovf_set", {63'd0, overflow_err}, 64'd1);
      repeat (3) step();
      @(negedge clk);
      chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
      step();

      // reset during back-to-back streaming
      for (int i = 0; i < 4; i++) send_word(32'hB000_0000 + i);
      reset      = 1'b1;
      din_TVALID = 1'b1;
      din_TDATA  = 32'hBAD0_BAD0;
      step();
      reset  = 1'b0;
      m_addr = '0;
      m_cred = 128;
      @(negedge clk);
      chk("mrst_pkt", {15'd0, dout}, 64'd0);
      chk("mrst_tready", {63'd0, din_TREADY}, 64'd0);
      chk("mrst_credits", {56'd0, credits}, 64'd128);
      chk("mrst_ovf", {63'd0, overflow_err}, 64'd0);
      chk("mrst_queue", 64'(q.size()), 64'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mrst_idle", {63'd0, din_TREADY}, 64'd0);
         step();
      end
      din_TVALID = 1'b0;
      start(5'd1, 4'd15);
      send_word(32'h0123_4567);
      @(negedge clk);
      chk("restart_pkt", {15'd0, dout},
          {15'd0, 1'b1, 5'd1, 4'd15, 7'd0, 32'h0123_4567});
      step();
      repeat (2) step();
      chk("final_queue", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
